// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants for the 16-bit, 16-register 5-stage core.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipeline_pkg;

  localparam int ALUOP_W = 4;

  // Writes to R0 are discarded, so R0 never carries a producer dependence.
  localparam logic [3:0] REG_ZERO = 4'd0;

  // ALU operation encodings carried in the control bundle.
  localparam logic [ALUOP_W-1:0] ALU_ADD = 4'h0;
  localparam logic [ALUOP_W-1:0] ALU_SUB = 4'h1;
  localparam logic [ALUOP_W-1:0] ALU_AND = 4'h2;
  localparam logic [ALUOP_W-1:0] ALU_OR  = 4'h3;
  localparam logic [ALUOP_W-1:0] ALU_XOR = 4'h4;
  localparam logic [ALUOP_W-1:0] ALU_SLL = 4'h5;
  localparam logic [ALUOP_W-1:0] ALU_SRL = 4'h6;
  localparam logic [ALUOP_W-1:0] ALU_SLT = 4'h7;

  // Control bundle travelling down the pipeline with each instruction.
  typedef struct packed {
    logic               regWrite;
    logic               memRead;
    logic               memWrite;
    logic               memToReg;
    logic [ALUOP_W-1:0] aluOp;
  } ctrl_t;

  // All-zero control is a harmless bubble in every pipeline register.
  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection between the decode slot and a load sitting in EX.
// Latency: purely combinational, same cycle.
// Backpressure: stall is suppressed while a flush kills the slot or a global freeze holds the pipe.
module hazard_detect
  import pipeline_pkg::*;
#(
  parameter int REG_W = 4
) (
  input  logic             idValid,
  input  logic [REG_W-1:0] idRs,
  input  logic [REG_W-1:0] idRt,
  input  logic             idUsesRs,
  input  logic             idUsesRt,
  input  logic             idMemWrite,
  input  logic             exValid,
  input  logic             exMemRead,
  input  logic [REG_W-1:0] exRd,
  input  logic             flush,
  input  logic             freeze,
  output logic             loadUse,
  output logic             stall
);

  logic rsHit;
  logic rtHit;

  // A store whose only dependence is its data operand (Rt) is covered by
  // MEM-to-MEM forwarding; a dependent base register still needs the bubble.
  always_comb begin
    rsHit   = idUsesRs & (exRd == idRs);
    rtHit   = idUsesRt & (exRd == idRt) & ~(idMemWrite & ~rsHit);
    loadUse = idValid & exValid & exMemRead &
              (exRd != REG_W'(REG_ZERO)) & (rsHit | rtHit);
    stall   = loadUse & ~flush & ~freeze;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and a saturating bubble counter.
// Latency: one cycle from ID_* to IDEX_*; Stall is combinational in the same cycle.
// Backpressure: Freeze holds all state; Stall holds PC and IF/ID while one bubble is inserted.
module id_ex_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ID_Valid,
  input  logic [REG_W-1:0]  ID_Rs,
  input  logic [REG_W-1:0]  ID_Rt,
  input  logic [REG_W-1:0]  ID_Rd,
  input  logic              ID_UsesRs,
  input  logic              ID_UsesRt,
  input  logic              ID_RegWrite,
  input  logic              ID_MemRead,
  input  logic              ID_MemWrite,
  input  logic              ID_MemToReg,
  input  logic [3:0]        ID_ALUOp,
  input  logic [DATA_W-1:0] ID_RsData,
  input  logic [DATA_W-1:0] ID_RtData,
  input  logic [DATA_W-1:0] ID_Imm,
  input  logic              Flush,
  input  logic              Freeze,
  output logic              Stall,
  output logic              IDEX_Valid,
  output logic [REG_W-1:0]  IDEX_Rs,
  output logic [REG_W-1:0]  IDEX_Rt,
  output logic [REG_W-1:0]  IDEX_Rd,
  output logic              IDEX_RegWrite,
  output logic              IDEX_MemRead,
  output logic              IDEX_MemWrite,
  output logic              IDEX_MemToReg,
  output logic [3:0]        IDEX_ALUOp,
  output logic [DATA_W-1:0] IDEX_RsData,
  output logic [DATA_W-1:0] IDEX_RtData,
  output logic [DATA_W-1:0] IDEX_Imm,
  output logic [CNT_W-1:0]  StallCount
);

  ctrl_t       idCtrl;
  ctrl_t       exCtrl;
  logic        loadUse;
  logic        loadBubble;

  assign idCtrl = '{regWrite: ID_RegWrite, memRead: ID_MemRead, memWrite: ID_MemWrite,
                    memToReg: ID_MemToReg, aluOp: ID_ALUOp};

  assign IDEX_RegWrite = exCtrl.regWrite;
  assign IDEX_MemRead  = exCtrl.memRead;
  assign IDEX_MemWrite = exCtrl.memWrite;
  assign IDEX_MemToReg = exCtrl.memToReg;
  assign IDEX_ALUOp    = exCtrl.aluOp;

  hazard_detect #(
    .REG_W(REG_W)
  ) uHazard (
    .idValid   (ID_Valid),
    .idRs      (ID_Rs),
    .idRt      (ID_Rt),
    .idUsesRs  (ID_UsesRs),
    .idUsesRt  (ID_UsesRt),
    .idMemWrite(ID_MemWrite),
    .exValid   (IDEX_Valid),
    .exMemRead (exCtrl.memRead),
    .exRd      (IDEX_Rd),
    .flush     (Flush),
    .freeze    (Freeze),
    .loadUse   (loadUse),
    .stall     (Stall)
  );

  // Flush, a load-use hazard and an empty decode slot all load the same
  // all-zero bubble; which one caused it only matters to the counter.
  assign loadBubble = Flush | loadUse | ~ID_Valid;

  // Pipeline register: hold on freeze, otherwise bubble or capture decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      IDEX_Valid  <= 1'b0;
      IDEX_Rs     <= '0;
      IDEX_Rt     <= '0;
      IDEX_Rd     <= '0;
      exCtrl      <= CTRL_NOP;
      IDEX_RsData <= '0;
      IDEX_RtData <= '0;
      IDEX_Imm    <= '0;
    end else if (!Freeze) begin
      if (loadBubble) begin
        IDEX_Valid  <= 1'b0;
        IDEX_Rs     <= '0;
        IDEX_Rt     <= '0;
        IDEX_Rd     <= '0;
        exCtrl      <= CTRL_NOP;
        IDEX_RsData <= '0;
        IDEX_RtData <= '0;
        IDEX_Imm    <= '0;
      end else begin
        IDEX_Valid  <= 1'b1;
        IDEX_Rs     <= ID_Rs;
        IDEX_Rt     <= ID_Rt;
        IDEX_Rd     <= ID_Rd;
        exCtrl      <= idCtrl;
        IDEX_RsData <= ID_RsData;
        IDEX_RtData <= ID_RtData;
        IDEX_Imm    <= ID_Imm;
      end
    end
  end

  // Count inserted load-use bubbles; a flush that wins the same cycle is not one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      StallCount <= '0;
    end else if (!Freeze && !Flush && loadUse && (StallCount != {CNT_W{1'b1}})) begin
      StallCount <= StallCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed checks of id_ex_stage against a behavioural model.
// Latency: model expects one-cycle capture and same-cycle Stall.
// Backpressure: exercises Freeze, Flush and load-use bubbles.
module tb_id_ex_stage;
  import pipeline_pkg::*;

  localparam int DW = 16;
  localparam int RW = 4;
  localparam int CW = 8;   // narrow counter so saturation is reachable quickly
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  typedef struct {
    logic          valid;
    logic [RW-1:0] rs, rt, rd;
    logic          usesRs, usesRt;
    logic          regWrite, memRead, memWrite, memToReg;
    logic [3:0]    aluOp;
    logic [DW-1:0] rsData, rtData, imm;
  } instr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  instr_t stim;
  logic flush, freeze;

  logic          Stall, IDEX_Valid, IDEX_RegWrite, IDEX_MemRead, IDEX_MemWrite, IDEX_MemToReg;
  logic [RW-1:0] IDEX_Rs, IDEX_Rt, IDEX_Rd;
  logic [3:0]    IDEX_ALUOp;
  logic [DW-1:0] IDEX_RsData, IDEX_RtData, IDEX_Imm;
  logic [CW-1:0] StallCount;

  // Reference state: the instruction believed to sit in EX, and the bubble count.
  instr_t        mEx;
  logic [CW-1:0] mCnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(DW), .REG_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_Valid(stim.valid), .ID_Rs(stim.rs), .ID_Rt(stim.rt), .ID_Rd(stim.rd),
    .ID_UsesRs(stim.usesRs), .ID_UsesRt(stim.usesRt),
    .ID_RegWrite(stim.regWrite), .ID_MemRead(stim.memRead),
    .ID_MemWrite(stim.memWrite), .ID_MemToReg(stim.memToReg),
    .ID_ALUOp(stim.aluOp), .ID_RsData(stim.rsData), .ID_RtData(stim.rtData),
    .ID_Imm(stim.imm), .Flush(flush), .Freeze(freeze), .Stall(Stall),
    .IDEX_Valid(IDEX_Valid), .IDEX_Rs(IDEX_Rs), .IDEX_Rt(IDEX_Rt), .IDEX_Rd(IDEX_Rd),
    .IDEX_RegWrite(IDEX_RegWrite), .IDEX_MemRead(IDEX_MemRead),
    .IDEX_MemWrite(IDEX_MemWrite), .IDEX_MemToReg(IDEX_MemToReg),
    .IDEX_ALUOp(IDEX_ALUOp), .IDEX_RsData(IDEX_RsData), .IDEX_RtData(IDEX_RtData),
    .IDEX_Imm(IDEX_Imm), .StallCount(StallCount)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic instr_t nop();
    instr_t n;
    n = '{valid: 1'b0, rs: '0, rt: '0, rd: '0, usesRs: 1'b0, usesRt: 1'b0,
          regWrite: 1'b0, memRead: 1'b0, memWrite: 1'b0, memToReg: 1'b0,
          aluOp: '0, rsData: '0, rtData: '0, imm: '0};
    return n;
  endfunction

  // A real load in EX producing a live register blocks any decode instruction
  // that needs that register as an ALU/address operand; store data is exempt
  // because it can be forwarded straight into memory.
  function automatic logic needsBubble(input instr_t id, input instr_t ex);
    logic producer, needRs, needRt;
    producer = id.valid && ex.valid && ex.memRead && (ex.rd != 0);
    needRs   = id.usesRs && (id.rs == ex.rd);
    needRt   = id.usesRt && (id.rt == ex.rd) && !id.memWrite;
    return producer && (needRs || needRt);
  endfunction

  task automatic modelEdge();
    logic lu;
    lu = needsBubble(stim, mEx);
    if (!freeze) begin
      if (flush || lu || !stim.valid) mEx = nop();
      else mEx = stim;
      if (!flush && lu && mCnt != CNT_MAX) mCnt = mCnt + 1'b1;
    end
  endtask

  task automatic checkOutputs(input string tag);
    checkVal({tag, ".valid"}, 32'(IDEX_Valid), 32'(mEx.valid));
    checkVal({tag, ".rs"}, 32'(IDEX_Rs), 32'(mEx.rs));
    checkVal({tag, ".rt"}, 32'(IDEX_Rt), 32'(mEx.rt));
    checkVal({tag, ".rd"}, 32'(IDEX_Rd), 32'(mEx.rd));
    checkVal({tag, ".ctrl"},
             32'({IDEX_RegWrite, IDEX_MemRead, IDEX_MemWrite, IDEX_MemToReg, IDEX_ALUOp}),
             32'({mEx.regWrite, mEx.memRead, mEx.memWrite, mEx.memToReg, mEx.aluOp}));
    checkVal({tag, ".rsData"}, 32'(IDEX_RsData), 32'(mEx.rsData));
    checkVal({tag, ".rtData"}, 32'(IDEX_RtData), 32'(mEx.rtData));
    checkVal({tag, ".imm"}, 32'(IDEX_Imm), 32'(mEx.imm));
    checkVal({tag, ".cnt"}, 32'(StallCount), 32'(mCnt));
  endtask

  // Called shortly after a falling edge with inputs already applied.
  task automatic cycle(input string tag);
    logic expStall;
    #1;
    expStall = needsBubble(stim, mEx) && !flush && !freeze;
    checkVal({tag, ".stall"}, 32'(Stall), 32'(expStall));
    modelEdge();
    @(posedge clk);
    #1;
    checkOutputs(tag);
    @(negedge clk);
  endtask

  function automatic instr_t mkLoad(input logic [RW-1:0] rd, input logic [RW-1:0] base);
    instr_t n;
    n = nop();
    n.valid = 1'b1; n.rd = rd; n.rs = base; n.usesRs = 1'b1;
    n.regWrite = 1'b1; n.memRead = 1'b1; n.memToReg = 1'b1;
    n.aluOp = ALU_ADD; n.imm = 16'h0004;
    return n;
  endfunction

  function automatic instr_t mkAlu(input logic [RW-1:0] rd, input logic [RW-1:0] rs,
                                   input logic [RW-1:0] rt);
    instr_t n;
    n = nop();
    n.valid = 1'b1; n.rd = rd; n.rs = rs; n.rt = rt;
    n.usesRs = 1'b1; n.usesRt = 1'b1; n.regWrite = 1'b1; n.aluOp = ALU_ADD;
    n.rsData = 16'(rs) * 16'h0101; n.rtData = 16'(rt) * 16'h0011;
    return n;
  endfunction

  function automatic instr_t mkStore(input logic [RW-1:0] data, input logic [RW-1:0] base);
    instr_t n;
    n = nop();
    n.valid = 1'b1; n.rs = base; n.rt = data; n.usesRs = 1'b1; n.usesRt = 1'b1;
    n.memWrite = 1'b1; n.aluOp = ALU_ADD;
    return n;
  endfunction

  function automatic instr_t mkRandom();
    instr_t n;
    n.valid    = ($urandom_range(0, 7) != 0);
    n.rs       = RW'($urandom_range(0, 3));
    n.rt       = RW'($urandom_range(0, 3));
    n.rd       = RW'($urandom_range(0, 3));
    n.usesRs   = 1'($urandom);
    n.usesRt   = 1'($urandom);
    n.regWrite = 1'($urandom);
    n.memRead  = ($urandom_range(0, 2) == 0);
    n.memWrite = ($urandom_range(0, 3) == 0);
    n.memToReg = 1'($urandom);
    n.aluOp    = 4'($urandom);
    n.rsData   = 16'($urandom);
    n.rtData   = 16'($urandom);
    n.imm      = 16'($urandom);
    return n;
  endfunction

  logic [CW-1:0] cntBefore;

  initial begin
    stim = nop(); flush = 1'b0; freeze = 1'b0;
    mEx = nop(); mCnt = '0;
    #2;
    checkOutputs("reset");
    checkVal("reset.stall", 32'(Stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Load-use: LW R3 then ADD R4,R3,R5.
    stim = mkLoad(4'd3, 4'd1); cycle("t1.lw");
    stim = mkAlu(4'd4, 4'd3, 4'd5);
    #1 checkVal("t1.stallHigh", 32'(Stall), 32'd1);
    cycle("t1.bubble");
    checkVal("t1.bubbleValid", 32'(IDEX_Valid), 32'd0);
    checkVal("t1.count", 32'(StallCount), 32'd1);
    cycle("t1.advance");
    checkVal("t1.advRs", 32'(IDEX_Rs), 32'd3);
    checkVal("t1.advValid", 32'(IDEX_Valid), 32'd1);

    // Store-data exemption, then dependent store base.
    stim = mkLoad(4'd6, 4'd1); cycle("t2.lw");
    stim = mkStore(4'd6, 4'd2);
    #1 checkVal("t2.noStall", 32'(Stall), 32'd0);
    cycle("t2.sw");
    checkVal("t2.swCaptured", 32'(IDEX_MemWrite), 32'd1);
    stim = mkLoad(4'd6, 4'd1); cycle("t2.lw2");
    stim = mkStore(4'd1, 4'd6);
    #1 checkVal("t2.baseStall", 32'(Stall), 32'd1);
    cycle("t2.bubble");
    cycle("t2.swAdvance");

    // R0 destination never stalls.
    stim = mkLoad(4'd0, 4'd1); cycle("t3.lw");
    cntBefore = StallCount;
    stim = mkAlu(4'd1, 4'd0, 4'd0);
    #1 checkVal("t3.noStall", 32'(Stall), 32'd0);
    cycle("t3.add");
    checkVal("t3.countSame", 32'(StallCount), 32'(cntBefore));

    // Flush wins over load-use.
    stim = mkLoad(4'd2, 4'd1); cycle("t4.lw");
    cntBefore = StallCount;
    stim = mkAlu(4'd5, 4'd2, 4'd2); flush = 1'b1;
    #1 checkVal("t4.noStall", 32'(Stall), 32'd0);
    cycle("t4.flush");
    flush = 1'b0;
    checkVal("t4.bubble", 32'(IDEX_Valid), 32'd0);
    checkVal("t4.countSame", 32'(StallCount), 32'(cntBefore));

    // Freeze hold with a hazard-shaped load parked in EX.
    stim = mkLoad(4'd7, 4'd1); stim.rsData = 16'hBEEF; cycle("t5.lw");
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      stim = mkAlu(4'd2, 4'd7, RW'(i));
      stim.rsData = 16'(i) + 16'h1000;
      cycle("t5.frozen");
      checkVal("t5.rdHeld", 32'(IDEX_Rd), 32'd7);
      checkVal("t5.dataHeld", 32'(IDEX_RsData), 32'h0000BEEF);
    end
    freeze = 1'b0;
    stim = mkAlu(4'd9, 4'd1, 4'd2); stim.rsData = 16'h1234;
    cycle("t5.release");
    checkVal("t5.capture", 32'(IDEX_RsData), 32'h00001234);

    // Saturation of the bubble counter.
    for (int i = 0; i < 300; i++) begin
      stim = mkLoad(4'd1, 4'd2); cycle("t6.lw");
      stim = mkAlu(4'd3, 4'd1, 4'd4); cycle("t6.use");
    end
    checkVal("t6.saturated", 32'(StallCount), 32'(CNT_MAX));

    // Async reset in the middle of a stall.
    stim = mkLoad(4'd5, 4'd2); cycle("t6.lwR");
    stim = mkAlu(4'd6, 4'd5, 4'd1);
    #1 checkVal("t6.preResetStall", 32'(Stall), 32'd1);
    rst_n = 1'b0;
    #1;
    mEx = nop(); mCnt = '0;
    checkVal("t6.resetStall", 32'(Stall), 32'd0);
    checkOutputs("t6.reset");
    rst_n = 1'b1;
    cycle("t6.afterReset");

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      stim   = mkRandom();
      flush  = ($urandom_range(0, 7) == 0);
      freeze = ($urandom_range(0, 7) == 0);
      cycle("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
